// File: rtl/median_stream_pkg.sv
// Shared definitions for the median streaming front end: default widths,
// frame length and the window-feeder state encoding.
package median_stream_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int FRAME_LEN_DEF = 8535;

   typedef enum logic [1:0] {
      FILL0  = 2'd0,
      FILL1  = 2'd1,
      STREAM = 2'd2
   } feed_state_e;

endpackage

// File: rtl/median_window_reg.sv
// Three-word output holding register with valid/ready handshake.
// A load wins over a take in the same cycle, so the new window replaces the taken one.
module median_window_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_word0,
   input  logic [DATA_W-1:0] load_word1,
   input  logic [DATA_W-1:0] load_word2,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_word0,
   output logic [DATA_W-1:0] out_word1,
   output logic [DATA_W-1:0] out_word2
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] word0_q, word0_d;
   logic [DATA_W-1:0] word1_q, word1_d;
   logic [DATA_W-1:0] word2_q, word2_d;

   always_comb begin
      valid_d = valid_q;
      word0_d = word0_q;
      word1_d = word1_q;
      word2_d = word2_q;
      if (load) begin
         valid_d = 1'b1;
         word0_d = load_word0;
         word1_d = load_word1;
         word2_d = load_word2;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         word0_q <= '0;
         word1_q <= '0;
         word2_q <= '0;
      end else begin
         valid_q <= valid_d;
         word0_q <= word0_d;
         word1_q <= word1_d;
         word2_q <= word2_d;
      end
   end

   assign out_valid = valid_q;
   assign out_word0 = word0_q;
   assign out_word1 = word1_q;
   assign out_word2 = word2_q;

endmodule

// File: rtl/median_window_feeder.sv
// Forms sliding three-sample windows from one sample stream; windows never
// straddle a frame of FRAME_LEN samples.
module median_window_feeder
   import median_stream_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_word0,
   output logic [DATA_W-1:0] out_word1,
   output logic [DATA_W-1:0] out_word2,
   output logic              frame_done,
   output logic [31:0]       window_count
);

   localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   feed_state_e       state_q, state_d;
   logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
   logic [DATA_W-1:0] tap0_q, tap0_d;
   logic [DATA_W-1:0] tap1_q, tap1_d;
   logic              frame_done_q, frame_done_d;
   logic [31:0]       window_count_q, window_count_d;
   logic              accept;
   logic              load;

   // In FILL states no window is produced, so a held output never blocks input.
   assign in_ready = (state_q != STREAM) || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d        = state_q;
      sample_cnt_d   = sample_cnt_q;
      tap0_d         = tap0_q;
      tap1_d         = tap1_q;
      frame_done_d   = 1'b0;
      window_count_d = window_count_q;
      load           = 1'b0;
      if (accept) begin
         case (state_q)
            FILL0: begin
               tap1_d  = in_data;
               state_d = FILL1;
            end
            FILL1: begin
               tap0_d  = in_data;
               state_d = STREAM;
            end
            STREAM: begin
               load           = 1'b1;
               tap1_d         = tap0_q;
               tap0_d         = in_data;
               window_count_d = window_count_q + 32'd1;
            end
            default: begin
               state_d = FILL0;
            end
         endcase
         if (sample_cnt_q == LAST_CNT) begin
            sample_cnt_d = '0;
            state_d      = FILL0;
            frame_done_d = 1'b1;
         end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
         end
      end else begin
         load = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= FILL0;
         sample_cnt_q   <= '0;
         tap0_q         <= '0;
         tap1_q         <= '0;
         frame_done_q   <= 1'b0;
         window_count_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         sample_cnt_q   <= sample_cnt_d;
         tap0_q         <= tap0_d;
         tap1_q         <= tap1_d;
         frame_done_q   <= frame_done_d;
         window_count_q <= window_count_d;
      end
   end

   median_window_reg #(
      .DATA_W (DATA_W)
   ) u_window_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_word0 (tap1_q),
      .load_word1 (tap0_q),
      .load_word2 (in_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_word0  (out_word0),
      .out_word1  (out_word1),
      .out_word2  (out_word2)
   );

   assign frame_done   = frame_done_q;
   assign window_count = window_count_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench: a short-frame instance under directed and random traffic,
// and a default-length instance streamed through one full frame.
module tb_median_window_feeder;

   localparam int SFL = 5;
   localparam int BFL = 8535;

   typedef struct {
      logic [95:0] w;
      bit          last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, frame_done;
   logic [31:0] in_data = 32'd0, out_word0, out_word1, out_word2, window_count;

   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, frame_done_b;
   logic [31:0] in_data_b = 32'd0, out_word0_b, out_word1_b, out_word2_b, window_count_b;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic [31:0] frame_q[$];
   bit   rand_mode = 0;
   bit   fd_seen = 0;
   int   big_k = 0;
   int   big_fd = 0;
   logic [95:0] big_last = 96'd0;

   always #5 clk = ~clk;

   median_window_feeder #(.DATA_W(32), .FRAME_LEN(SFL)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_word0(out_word0),
      .out_word1(out_word1), .out_word2(out_word2), .frame_done(frame_done),
      .window_count(window_count)
   );

   median_window_feeder u_big (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_word0(out_word0_b),
      .out_word1(out_word1_b), .out_word2(out_word2_b), .frame_done(frame_done_b),
      .window_count(window_count_b)
   );

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: a window is every run of three consecutive samples inside one frame.
   task automatic model_accept(input logic [31:0] d);
      int n;
      exp_t e;
      frame_q.push_back(d);
      n = frame_q.size();
      if (n >= 3) begin
         e.w    = {frame_q[n-3], frame_q[n-2], frame_q[n-1]};
         e.last = (n == SFL);
         exp_q.push_back(e);
      end
      if (n == SFL) frame_q.delete();
   endtask

   task automatic send(input logic [31:0] d);
      bit acc;
      int budget;
      if (rand_mode) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data  = d;
      acc      = 0;
      budget   = 0;
      while (!acc && budget < 200) begin
         if (rand_mode) out_ready = 1'($urandom_range(0, 1));
         #4;
         acc = in_ready;
         @(negedge clk);
         budget++;
      end
      in_valid = 1'b0;
      if (acc) model_accept(d);
      else chk("send_timeout", 96'd0, 96'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("drain_empty", 96'(exp_q.size()), 96'd0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      frame_q.delete();
   endtask

   // Scoreboard monitor for the short-frame instance.
   always @(negedge clk) begin
      #3;
      if (rst) begin
         exp_q.delete();
         fd_seen = 0;
      end else begin
         if (out_valid && exp_q.size() == 0) chk("valid_without_window", 96'd1, 96'd0);
         if (frame_done) begin
            if (exp_q.size() == 0) chk("fd_no_window", 96'd0, 96'd1);
            else begin
               chk("fd_on_last", {94'd0, out_valid, exp_q[0].last}, 96'd3);
               fd_seen = 1;
            end
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("window", {out_word0, out_word1, out_word2}, e.w);
            if (e.last) chk("fd_for_last", 96'(fd_seen), 96'd1);
            fd_seen = 0;
         end
      end
   end

   // Monitor for the default-length instance: windows must be (k, k+1, k+2).
   always @(negedge clk) begin
      #3;
      if (!rst) begin
         if (frame_done_b) big_fd++;
         if (out_valid_b && out_ready_b) begin
            chk("big_window", {out_word0_b, out_word1_b, out_word2_b},
                {32'(big_k), 32'(big_k + 1), 32'(big_k + 2)});
            big_last = {out_word0_b, out_word1_b, out_word2_b};
            big_k++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #3;
      chk("rst_out_valid", 96'(out_valid), 96'd0);
      chk("rst_words", {out_word0, out_word1, out_word2}, 96'd0);
      chk("rst_frame_done", 96'(frame_done), 96'd0);
      chk("rst_window_count", 96'(window_count), 96'd0);
      chk("rst_in_ready", 96'(in_ready), 96'd1);
      @(negedge clk);

      // Plain frame with the consumer always ready
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) send(32'(i));
      drain();
      chk("wc_single_frame", 96'(window_count), 96'd3);

      // Back-pressure holds the first window and stalls the input
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) send(32'(i));
      in_valid = 1'b1;
      in_data  = 32'd4;
      for (int c = 0; c < 2; c++) begin
         #4;
         chk("bp_in_ready", 96'(in_ready), 96'd0);
         chk("bp_hold", {out_valid, out_word0, out_word1, out_word2}, {1'b1, 32'd1, 32'd2, 32'd3});
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(32'd4);
      send(32'd5);
      drain();

      // Two frames back to back
      do_reset();
      for (int i = 1; i <= 5; i++) send(32'(i));
      for (int i = 10; i <= 14; i++) send(32'(i));
      drain();
      chk("wc_two_frames", 96'(window_count), 96'd6);

      // Reset with a held window discards it
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) send(32'(i));
      do_reset();
      #3;
      chk("mid_rst_out_valid", 96'(out_valid), 96'd0);
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 7; i <= 9; i++) send(32'(i));
      drain();
      chk("wc_after_rst", 96'(window_count), 96'd1);

      // Random bubbles and back-pressure
      do_reset();
      rand_mode = 1;
      for (int i = 1; i <= 5; i++) send(32'(i));
      for (int i = 0; i < 40; i++) send($urandom);
      rand_mode = 0;
      drain();
      chk("wc_random", 96'(window_count), 96'd27);

      // Default frame length, one full frame
      for (int i = 0; i < BFL; i++) begin
         int budget;
         bit acc;
         in_valid_b = 1'b1;
         in_data_b  = 32'(i);
         acc        = 0;
         budget     = 0;
         while (!acc && budget < 50) begin
            #4;
            acc = in_ready_b;
            @(negedge clk);
            budget++;
         end
         if (!acc) chk("big_send_timeout", 96'd0, 96'd1);
      end
      in_valid_b = 1'b0;
      repeat (4) @(negedge clk);
      chk("big_windows_seen", 96'(big_k), 96'd8533);
      chk("big_window_count", 96'(window_count_b), 96'd8533);
      chk("big_frame_done_count", 96'(big_fd), 96'd1);
      chk("big_last_window", big_last, {32'd8532, 32'd8533, 32'd8534});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
